// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit correction constants and a width helper.
package bin_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // A digit at or above the threshold would exceed 9 after doubling.
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit add-3 correction used before each double-dabble shift.
module bcd_digit_adj
    import bin_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add 3 to any digit that would overflow a decimal digit when doubled.
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// start/busy/done handshake, result and overflow held until next done.
module bin_bcd_seq
    import bin_bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);

    state_t             state_r, state_s;
    logic [BCD_W-1:0]   bcd_r, bcd_s;
    logic [BIN_W-1:0]   bin_r, bin_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               ovf_acc_r, ovf_acc_s;
    logic [BCD_W-1:0]   bcd_out_r, bcd_out_s;
    logic               overflow_r, overflow_s;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   bcd_shift_s;
    logic               ovf_shift_s;

    // One correction stage per digit of the working BCD field.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_r[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // Corrected digits shift left, taking the next binary MSB; the bit
    // falling off the top digit means the value needs more digits.
    assign bcd_shift_s = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
    assign ovf_shift_s = ovf_acc_r | adj_s[BCD_W-1];

    // Next-state and datapath update selection.
    always_comb begin
        state_s    = state_r;
        bcd_s      = bcd_r;
        bin_s      = bin_r;
        cnt_s      = cnt_r;
        ovf_acc_s  = ovf_acc_r;
        bcd_out_s  = bcd_out_r;
        overflow_s = overflow_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = CONV;
                    bin_s     = bin_in;
                    bcd_s     = {BCD_W{1'b0}};
                    ovf_acc_s = 1'b0;
                    cnt_s     = CNT_W'(BIN_W);
                end else begin
                    state_s   = IDLE;
                end
            end
            CONV: begin
                bcd_s     = bcd_shift_s;
                bin_s     = {bin_r[BIN_W-2:0], 1'b0};
                ovf_acc_s = ovf_shift_s;
                cnt_s     = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s    = DONE;
                    bcd_out_s  = bcd_shift_s;
                    overflow_s = ovf_shift_s;
                end else begin
                    state_s    = CONV;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working shift register, step counter and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r      <= {BCD_W{1'b0}};
            bin_r      <= {BIN_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            ovf_acc_r  <= 1'b0;
            bcd_out_r  <= {BCD_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            bcd_r      <= bcd_s;
            bin_r      <= bin_s;
            cnt_r      <= cnt_s;
            ovf_acc_r  <= ovf_acc_s;
            bcd_out_r  <= bcd_out_s;
            overflow_r <= overflow_s;
        end
    end

    assign busy     = (state_r == CONV);
    assign done     = (state_r == DONE);
    assign bcd_out  = bcd_out_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed testbench for bin_bcd_seq: a 3-digit and a 2-digit instance.
module tb_bin_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start3, start2;
    logic [7:0]  bin3, bin2;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;

    int n_checks;
    int n_fail;

    bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
    );

    bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference for 3-digit results.
    function automatic logic [11:0] ref_bcd3(input int v);
        logic [3:0] d2, d1, d0;
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d2, d1, d0};
    endfunction

    // One conversion on the chosen instance; reports result, busy/done
    // cycle counts and the number of edges from accept to done.
    task automatic run_conv(input bit two, input logic [7:0] v,
                            output logic [11:0] bcd, output logic ovf,
                            output int busy_cnt, output int done_cnt,
                            output int lat);
        @(negedge clk);
        if (two) begin start2 = 1'b1; bin2 = v; end
        else     begin start3 = 1'b1; bin3 = v; end
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        lat = -1;
        bcd = 12'hxxx;
        ovf = 1'bx;
        for (int i = 0; i < 12; i++) begin
            if (two ? busy2 : busy3) busy_cnt++;
            if (two ? done2 : done3) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i;
                    bcd = two ? {4'h0, bcd2} : bcd3;
                    ovf = two ? ovf2 : ovf3;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start3 = 1'b0; start2 = 1'b0;
        bin3 = 8'd0; bin2 = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy3, done3, ovf3, bcd3} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: busy=%b done=%b ovf=%b bcd=%h, required all zero",
                     busy3, done3, ovf3, bcd3);
        end
        n_checks++;
        if ({busy2, done2, ovf2, bcd2} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: busy=%b done=%b ovf=%b bcd=%h, required all zero",
                     busy2, done2, ovf2, bcd2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0]  vals [4];
        logic [11:0] exp  [4];
        logic [11:0] bcd;
        logic        ovf;
        int          bc, dc, lat;
        vals = '{8'd255, 8'd0, 8'd99, 8'd100};
        exp  = '{12'h255, 12'h000, 12'h099, 12'h100};
        for (int k = 0; k < 4; k++) begin
            run_conv(1'b0, vals[k], bcd, ovf, bc, dc, lat);
            n_checks++;
            if (bcd !== exp[k] || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_value(%0d): bcd=%h ovf=%b, required %h ovf=0",
                         vals[k], bcd, ovf, exp[k]);
            end
            n_checks++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL basic_latency(%0d): %0d edges, required 8", vals[k], lat);
            end
            n_checks++;
            if (bc != 8 || dc != 1) begin
                n_fail++;
                $display("FAIL basic_handshake(%0d): busy %0d cycles done %0d cycles, required 8 and 1",
                         vals[k], bc, dc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] prev;
        int          ndone;
        ndone = 0;
        prev  = bcd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done3) begin
                ndone++;
                n_checks++;
                if ((i - 9) % 10 != 0 || i < 9) begin
                    n_fail++;
                    $display("FAIL b2b_done_slot: done at cycle %0d, required cycles 9,19,29,39", i);
                end else if (bcd3 !== ref_bcd3((7 * (i - 9) + 3) % 256)) begin
                    n_fail++;
                    $display("FAIL b2b_value: cycle %0d bcd=%h, required %h", i, bcd3,
                             ref_bcd3((7 * (i - 9) + 3) % 256));
                end
                prev = bcd3;
            end else if (bcd3 !== prev) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_hold: cycle %0d bcd=%h changed without done, required %h",
                         i, bcd3, prev);
            end
            start3 = 1'b1;
            bin3 = 8'((7 * i + 3) % 256);
        end
        @(negedge clk);
        start3 = 1'b0;
        if (done3) ndone++;
        n_checks++;
        if (ndone != 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d done pulses, required 4", ndone);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        logic [11:0] bcd;
        logic        ovf;
        int          bc, dc, lat, seen;
        @(negedge clk);
        start3 = 1'b1; bin3 = 8'd200;
        @(negedge clk);
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: busy=%b done=%b bcd=%h ovf=%b, required 0 0 000 0",
                     busy3, done3, bcd3, ovf3);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done3 || busy3) seen++;
            @(negedge clk);
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: busy/done seen %0d cycles, required 0", seen);
        end
        run_conv(1'b0, 8'd37, bcd, ovf, bc, dc, lat);
        n_checks++;
        if (bcd !== 12'h037 || ovf !== 1'b0 || lat != 8) begin
            n_fail++;
            $display("FAIL midrst_after: bcd=%h ovf=%b lat=%0d, required 037 0 8", bcd, ovf, lat);
        end
    endtask

    task automatic test_two_digits();
        logic [7:0]  vals [3];
        logic [11:0] exp  [3];
        logic        eovf [3];
        logic [11:0] bcd;
        logic        ovf;
        int          bc, dc, lat;
        vals = '{8'd99, 8'd100, 8'd255};
        exp  = '{12'h099, 12'h000, 12'h055};
        eovf = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_conv(1'b1, vals[k], bcd, ovf, bc, dc, lat);
            n_checks++;
            if (bcd !== exp[k] || ovf !== eovf[k] || lat != 8) begin
                n_fail++;
                $display("FAIL two_digit(%0d): bcd=%h ovf=%b lat=%0d, required %h ovf=%b lat=8",
                         vals[k], bcd[7:0], ovf, lat, exp[k][7:0], eovf[k]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [11:0] bcd;
        logic        ovf;
        int          bc, dc, lat, dec;
        for (int v = 0; v < 256; v++) begin
            run_conv(1'b0, 8'(v), bcd, ovf, bc, dc, lat);
            dec = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
            n_checks++;
            if (bcd[11:8] > 4'd9 || bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9 ||
                dec != v || ovf !== 1'b0 || lat != 8) begin
                n_fail++;
                $display("FAIL sweep(%0d): bcd=%h ovf=%b lat=%0d, required %h ovf=0 lat=8",
                         v, bcd, ovf, lat, ref_bcd3(v));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_conv();
        test_two_digits();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
